cc_branch_unit: RTL
===================

CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

Interface
REQ-001 The parameter list SHALL be: DEPTH, 4, number of entries in the flag save stack (power of two, 2..16).
REQ-002 The ports SHALL include: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The ports SHALL include: rst  input  1  synchronous, active-high reset.
REQ-004 The ports SHALL include: cc_we  input  1  latch the Z_in/V_in/C_in/N_in flags from the ALU.
REQ-005 The ports SHALL include: Z_in, V_in, C_in, N_in  input  1 each  condition codes produced by the ALU this cycle.
REQ-006 The ports SHALL include: br_en  input  1  current instruction is a conditional branch.
REQ-007 The ports SHALL include: cond  input  4  branch condition code.
REQ-008 The ports SHALL include: push  input  1  save the flag register to the stack (interrupt entry).
REQ-009 The ports SHALL include: pop  input  1  restore the flag register from the stack (interrupt return).
REQ-010 The ports SHALL include: Z, V, C, N  output  1 each  registered flag state.
REQ-011 The ports SHALL include: Pre_C  output  1  registered carry to the ALU for ADC/SBB; always equal to C.
REQ-012 The ports SHALL include: br_taken  output  1  combinational branch decision.
REQ-013 The ports SHALL include: stack_full, stack_empty  output  1 each  stack status.
REQ-014 The ports SHALL include: err  output  1  sticky overflow/underflow flag.

Function
REQ-015 The flag register SHALL be 4 bits {N,Z,C,V}, and only this register SHALL drive Z/V/C/N/Pre_C.
REQ-016 When cc_we=1 and pop=0, the flags SHALL load Z_in/V_in/C_in/N_in at the clock edge; when cc_we=0, the flags SHALL hold.
REQ-017 br_taken SHALL equal br_en AND eval(cond) on the registered flags (pre-edge values); a same-cycle cc_we SHALL NOT affect it, and there is no bypass.
REQ-018 cond SHALL decode as: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-019 br_taken SHALL be 0 whenever br_en=0, regardless of cond.
REQ-020 The stack SHALL be a LIFO of DEPTH 4-bit entries with a pointer sp of width clog2(DEPTH)+1, where sp is the occupied-entry count.
REQ-021 stack_empty SHALL be (sp==0) and stack_full SHALL be (sp==DEPTH), both decoded from registered sp.
REQ-022 A push with !full and !pop SHALL write the pre-edge flag register into entry sp and set sp to sp+1; cc_we in the same cycle SHALL still update the flags afterwards, so the stack holds the old flags.
REQ-023 A pop with !empty and !push SHALL load the flags from entry sp-1, set sp to sp-1, and take priority over a same-cycle cc_we.
REQ-024 A push when full SHALL be dropped, leave sp and the stack unchanged, and set err.
REQ-025 A pop when empty SHALL leave the flags and sp unchanged, set err, and still allow a same-cycle cc_we to apply.
REQ-026 Simultaneous push and pop SHALL be a stack no-op (sp unchanged, no err), with the flags loaded from cc_we if asserted.
REQ-027 err SHALL be sticky and cleared only by rst.
REQ-028 The block SHALL use no latches and no multicycle paths; br_taken SHALL be the only combinational output.

Reset
REQ-029 While rst=1 at an edge, the flags SHALL become 0000, and Pre_C, sp and err SHALL become 0; stack_empty=1, stack_full=0; stack contents are don't-care.
REQ-030 rst SHALL override cc_we, push and pop in the same cycle, including reset in mid-interrupt-nesting.
REQ-031 br_taken after reset SHALL follow cond on the zero flags: EQ=0, NE=1, AL=1, GE=1.

Verification
REQ-032 Scenario: after rst, drive cc_we=1 with Z_in=1, C_in=1, N_in=0, V_in=0 -> next cycle Z=1, C=1, Pre_C=1; br_en=1 with cond=0,2,8,9 -> br_taken=1,1,0,1.
REQ-033 Scenario: flags N=1, V=0; cond A/B/C/D with br_en=1 -> br_taken=0/1/0/1; br_en=0 -> br_taken=0 for all 16 cond values.
REQ-034 Scenario: with flags 0010, assert push and cc_we (inputs 1000) together -> flags=1000, sp=1; then pop -> flags=0010, sp=0, stack_empty=1, err=0.
REQ-035 Scenario: 4 pushes of distinct flag values then a 5th push -> stack_full=1, err=1, sp stays 4; then 4 pops -> flags return in reverse order.
REQ-036 Scenario: pop when empty with cc_we=1 (inputs 0101) -> flags=0101, err=1, sp=0; err stays 1 until rst.
REQ-037 Scenario: assert push and pop together at sp=2 -> sp=2, no err; assert rst at sp=3 -> sp=0, flags=0000, err=0 on the next cycle.

Source files
------------

// File: rtl/cc_branch_unit.sv
// cc_branch_unit: condition-code register, branch condition evaluator and
// LIFO flag save stack for interrupt entry/return.
module cc_branch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cc_we,
    input  logic       Z_in,
    input  logic       V_in,
    input  logic       C_in,
    input  logic       N_in,
    input  logic       br_en,
    input  logic [3:0] cond,
    input  logic       push,
    input  logic       pop,
    output logic       Z,
    output logic       V,
    output logic       C,
    output logic       N,
    output logic       Pre_C,
    output logic       br_taken,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       err
);
    localparam int SPW = $clog2(DEPTH) + 1;
    logic [3:0]     flags_q, flags_d;
    logic [SPW-1:0] sp_q, sp_d, sp_m1;
    logic           err_q, err_d;
    logic [3:0]     stack_q [DEPTH];
    logic           do_push, do_pop;
    logic [15:0]    ev;
    assign stack_empty = sp_q == '0;
    assign stack_full  = sp_q == SPW'(DEPTH);
    assign sp_m1       = sp_q - 1'b1;
    assign do_push     = push & ~pop & ~stack_full;
    assign do_pop      = pop & ~push & ~stack_empty;
    assign {N, Z, C, V} = flags_q;
    assign Pre_C       = flags_q[1];
    assign err         = err_q;
    // Bit i of ev is the truth of condition code i on the registered flags.
    assign ev = {1'b0, 1'b1, Z | (N != V), ~Z & (N == V), N != V, N == V,
                 ~C | Z, C & ~Z, ~V, V, ~N, N, ~C, C, ~Z, Z};
    assign br_taken = br_en & ev[cond];
    always_comb begin
        flags_d = do_pop ? stack_q[sp_m1[SPW-2:0]]
                : cc_we  ? {N_in, Z_in, C_in, V_in} : flags_q;
        sp_d    = do_push ? sp_q + 1'b1 : do_pop ? sp_m1 : sp_q;
        err_d   = err_q | (push & ~pop & stack_full) | (pop & ~push & stack_empty);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            if (do_push) stack_q[sp_q[SPW-2:0]] <= flags_q;
        end
    end
endmodule
